// File: rtl/hm_pkg.sv
// Shared types and widths for the host-memory read sequencer.
package hm_pkg;

   localparam int unsigned HM_ADDR_W = 64;
   localparam int unsigned HM_CNT_W  = 16;

   typedef enum logic [2:0] {
      HM_IDLE,
      HM_ISSUE,
      HM_WAIT_TX,
      HM_WAIT_RX,
      HM_NEXT,
      HM_FINISH
   } hm_state_e;

   // Progress of the scan in flight: next request address and reads still owed.
   typedef struct packed {
      logic [HM_ADDR_W-1:0] addr;
      logic [HM_CNT_W-1:0]  remaining;
   } hm_scan_t;

endpackage

// File: rtl/hm_sched_timer.sv
// Loadable down-counter; expired_c is high while the count sits at zero.
module hm_sched_timer #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         expired_c
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/hm_sched.sv
// Host-memory read sequencer: one outstanding read at a time through hm_tx,
// advancing the address after each completion, with abort and timeout exits.
module hm_sched
   import hm_pkg::*;
#(
   parameter int unsigned STRIDE_LOG2 = 12,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 go,
   input  logic                 abort,
   input  logic [HM_ADDR_W-1:0] base_addr,
   input  logic [HM_CNT_W-1:0]  n_reads,
   output logic                 busy,
   output logic                 done,
   output logic                 err_timeout,
   output logic [HM_CNT_W-1:0]  reads_done,
   output logic                 tx_start,
   output logic [HM_ADDR_W-1:0] hm_addr,
   input  logic                 tx_end,
   input  logic                 rx_end
);

   localparam logic [HM_ADDR_W-1:0] STRIDE   = HM_ADDR_W'(1) << STRIDE_LOG2;
   localparam logic [HM_CNT_W-1:0]  TMO_LOAD = HM_CNT_W'(TIMEOUT - 1);

   hm_state_e           state_q, state_d;
   hm_scan_t            scan_q, scan_d;
   logic [HM_CNT_W-1:0] reads_done_q, reads_done_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                tx_start_q, tx_start_d;
   logic                tmo_load, tmo_en, tmo_expired;

   // Timer is armed on the WAIT_TX -> WAIT_RX hand-off and runs only in WAIT_RX.
   assign tmo_load = (state_q == HM_WAIT_TX) && tx_end;
   assign tmo_en   = (state_q == HM_WAIT_RX);

   hm_sched_timer #(
      .W (HM_CNT_W)
   ) u_timer (
      .clk_i      (sys_clk),
      .rst_i      (sys_rst),
      .load_i     (tmo_load),
      .load_val_i (TMO_LOAD),
      .en_i       (tmo_en),
      .expired_c  (tmo_expired)
   );

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= HM_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Abort beats a same-cycle completion in WAIT_RX; a completion beats expiry.
   always_comb begin
      state_d = state_q;
      case (state_q)
         HM_IDLE: begin
            if (go) begin
               state_d = (n_reads == '0) ? HM_FINISH : HM_ISSUE;
            end
         end
         HM_ISSUE:   state_d = HM_WAIT_TX;
         HM_WAIT_TX: begin
            if (tx_end) begin
               state_d = HM_WAIT_RX;
            end
         end
         HM_WAIT_RX: begin
            if (abort) begin
               state_d = HM_FINISH;
            end else if (rx_end) begin
               state_d = HM_NEXT;
            end else if (tmo_expired) begin
               state_d = HM_FINISH;
            end
         end
         HM_NEXT: begin
            if ((scan_q.remaining != '0) && !abort) begin
               state_d = HM_ISSUE;
            end else begin
               state_d = HM_FINISH;
            end
         end
         HM_FINISH:  state_d = HM_IDLE;
         default:    state_d = HM_IDLE;
      endcase
   end

   always_comb begin
      busy_d       = (state_d != HM_IDLE);
      done_d       = (state_d == HM_FINISH);
      tx_start_d   = (state_d == HM_ISSUE);
      scan_d       = scan_q;
      reads_done_d = reads_done_q;
      err_d        = err_q;
      if ((state_q == HM_IDLE) && go) begin
         scan_d.addr      = base_addr;
         scan_d.remaining = n_reads;
         reads_done_d     = '0;
         err_d            = 1'b0;
      end
      if ((state_q == HM_WAIT_RX) && (state_d == HM_NEXT)) begin
         scan_d.addr      = scan_q.addr + STRIDE;
         scan_d.remaining = scan_q.remaining - HM_CNT_W'(1);
         reads_done_d     = reads_done_q + HM_CNT_W'(1);
      end
      if ((state_q == HM_WAIT_RX) && (state_d == HM_FINISH) && !abort) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         scan_q       <= '0;
         reads_done_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         tx_start_q   <= 1'b0;
      end else begin
         scan_q       <= scan_d;
         reads_done_q <= reads_done_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         tx_start_q   <= tx_start_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign err_timeout = err_q;
   assign reads_done  = reads_done_q;
   assign tx_start    = tx_start_q;
   assign hm_addr     = scan_q.addr;

endmodule

// File: doc/hm_sched.md
# hm_sched

Sequencer for the host-memory read path: walks a contiguous host region by issuing one memory-read request at a time through `hm_tx`. It waits for the matching completion from the receive side before issuing the next request, and reports progress, completion and timeout to the control logic. It sits between the CSR/control layer and the `hm_tx`/`hm_rx` pair in the TRN clock domain, and owns `tx_start` and `hm_addr`.

## Interface
- `STRIDE_LOG2`, 12: address increment between requests is 2^STRIDE_LOG2 bytes.
- `TIMEOUT`, 1024: cycles allowed in WAIT_RX before the scan fails; legal range is 1..65535.
- `sys_clk  in  1`: clock, the same clock as `trn_clk` of `hm_tx`.
- `sys_rst  in  1`: reset, asynchronous, active-high.
- `go  in  1`: one-cycle start pulse; ignored while `busy`.
- `abort  in  1`: level input; stops the scan at the next safe point.
- `base_addr  in  64`: first request address, sampled on accepted `go`.
- `n_reads  in  16`: number of requests, sampled on accepted `go`.
- `busy  out  1`: high from the cycle after an accepted `go` until `done`.
- `done  out  1`: one-cycle pulse at the end of a scan; covers success, abort and timeout.
- `err_timeout  out  1`: sticky; cleared by the next accepted `go`.
- `reads_done  out  16`: completions received in the current scan.
- `tx_start  out  1`: one-cycle request to `hm_tx`.
- `hm_addr  out  64`: request address; held stable from `tx_start` until `tx_end`.
- `tx_end  in  1`: `hm_tx` finished sending the TLP.
- `rx_end  in  1`: one-cycle pulse; completion for the outstanding read received.

## Operation
- States and transitions:
  - IDLE → ISSUE on `go` with `n_reads`≠0.
  - IDLE → FINISH on `go` with `n_reads`=0.
  - ISSUE → WAIT_TX; ISSUE asserts `tx_start` for exactly 1 cycle.
  - WAIT_TX → WAIT_RX on `tx_end`.
  - WAIT_RX → NEXT on `rx_end`.
  - WAIT_RX → FINISH on timeout.
  - NEXT → ISSUE if remaining≠0 and `abort`=0; otherwise NEXT → FINISH.
  - FINISH → IDLE; FINISH pulses `done`.
- At most one read is outstanding at any time.
- On accepted `go`: latch `base_addr` into `hm_addr` and `n_reads` into the remaining counter; clear `reads_done` and `err_timeout`.
- In NEXT:
  - `hm_addr` += 2^STRIDE_LOG2, modulo 2^64 (wrap, no error).
  - Remaining counter decrements; `reads_done` increments.
- Timeout counter:
  - Cleared on entry to WAIT_RX, increments each WAIT_RX cycle.
  - When it reaches `TIMEOUT`-1 without `rx_end`, set `err_timeout` and go to FINISH.
  - `rx_end` in the expiry cycle wins: no timeout.
- Abort:
  - Honoured in IDLE (no effect), NEXT, and WAIT_RX (→ FINISH immediately; the completion is not counted).
  - Never honoured in ISSUE or WAIT_TX: a TLP in flight is always completed on TRN.
- `rx_end` outside WAIT_RX and `tx_end` outside WAIT_TX are ignored.
- `go` during `busy` is ignored; no queuing.
- Reset mid-scan: all state returns to IDLE immediately. `hm_tx` finishes its TLP independently; the stale `tx_end`/`rx_end` are ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `err_timeout`=0, `reads_done`=0, `tx_start`=0, `hm_addr`=0. State is IDLE.
- All outputs are registered.
- `go` at cycle N:
  - `busy`=1 and `tx_start`=1 at N+1, with `hm_addr`=`base_addr` valid the same cycle.
  - With `n_reads`=0: `done` and `busy` at N+1 only, and no `tx_start`.
- `tx_end` at cycle T: WAIT_RX from T+1.
- `rx_end` at cycle R:
  - `reads_done` updated at R+1 (NEXT).
  - If more reads remain: next `tx_start` at R+2.
  - After the last read: `done` at R+2, and `busy` falls at R+3.
- Timeout: WAIT_RX entered at W with no `rx_end` → `err_timeout` and FINISH at W+TIMEOUT, `done` the same cycle.
- Throughput per read = TX duration + completion latency + 3 cycles.

## Structure
- Shared package `hm_pkg`: state encoding (IDLE, ISSUE, WAIT_TX, WAIT_RX, NEXT, FINISH), address width 64, count width 16.
- Sub-module `hm_sched_timer`: loadable down-counter with an expiry flag. It is reused by future `hm_rx` watchdogs.
- Everything else is a single FSM module.

## Test plan
- Reset (`sys_rst` pulse) → `go` with `base_addr`=0x1000, `n_reads`=3, `tx_end` 5 cycles after `tx_start`, `rx_end` 4 cycles later → `tx_start` with `hm_addr` 0x1000, 0x2000, 0x3000; `reads_done`=3; one `done` pulse; `err_timeout`=0.
- `base_addr`=0xFFFF_FFFF_FFFF_F000, `n_reads`=2 → second `hm_addr` = 0x0 (wrap); scan completes normally.
- `n_reads`=0 → `done` 1 cycle after `go`; no `tx_start`; `reads_done`=0.
- `TIMEOUT`=16, `rx_end` never arrives → `err_timeout`=1 and `done` 16 cycles after WAIT_RX entry; `reads_done`=0. A following `go` clears `err_timeout`.
- `abort` asserted during WAIT_TX of read 2 of 4 → `tx_end` honoured; `done` the cycle after WAIT_RX entry; `reads_done`=1; no third `tx_start`.
- Second `go` while `busy`, plus stray `rx_end` in WAIT_TX → both ignored; counts and addresses unchanged.
- `sys_rst` asserted mid WAIT_RX → all outputs 0 asynchronously.
